// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

    // Width of one adder pass.
    localparam int unsigned NIBBLE_W = 4;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: sequences a WIDTH-bit add (or subtract) through an external
// 4-bit ripple-carry adder, one nibble per cycle, behind valid/ready handshakes.
// Optional feature macro: SUBTRACT_EN adds the op_sub input (A - B via ~B and carry-in 1).
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic                op_cin,
`ifdef SUBTRACT_EN
    input  logic                op_sub,
`endif
    output logic [NIBBLE_W-1:0] add_a,
    output logic [NIBBLE_W-1:0] add_b,
    output logic                add_cin,
    input  logic [NIBBLE_W-1:0] add_sum,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                carry_out,
    output logic                overflow,
    output logic                zero
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_d;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_beff;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;

    logic [WIDTH-1:0]   w_beff_in;
    logic               w_cin_in;
    logic               w_last;

    // Effective B operand and initial carry as seen at operand acceptance.
`ifdef SUBTRACT_EN
    always_comb begin
        w_beff_in = op_sub ? ~op_b : op_b;
        w_cin_in  = op_sub ? 1'b1  : op_cin;
    end
`else
    always_comb begin
        w_beff_in = op_b;
        w_cin_in  = op_cin;
    end
`endif

    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic plus handshake and adder-port outputs.
    always_comb begin
        w_state_d = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                add_a   = r_a[r_idx * NIBBLE_W +: NIBBLE_W];
                add_b   = r_beff[r_idx * NIBBLE_W +: NIBBLE_W];
                add_cin = r_carry;
                if (w_last) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Operand latch, per-nibble result capture and carry chaining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_beff  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_beff  <= w_beff_in;
                        r_carry <= w_cin_in;
                        r_res   <= '0;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_res[r_idx * NIBBLE_W +: NIBBLE_W] <= add_sum;
                    r_carry                             <= add_cout;
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result and flags come straight from registers; meaningful while out_valid is high.
    always_comb begin
        result    = r_res;
        carry_out = r_carry;
        zero      = (r_res == '0);
        overflow  = (r_a[WIDTH-1] == r_beff[WIDTH-1]) && (r_res[WIDTH-1] != r_a[WIDTH-1]);
    end

endmodule
